order_group_sort: RTL
=====================

Name: order_group_sort

Overview:
- Parametrised successor to the fixed 25-lane group-sort model.
- Takes NUM lanes of DSIZE-bit data as one packed bus.
  - Passes the first BYPASS lanes through, delay-matched.
  - Splits the remaining lanes into groups of GSIZE, plus one tail group of size (NUM-BYPASS) mod GSIZE.
  - Sorts each group independently through a pipelined odd-even transposition network.
- Adds a valid/ready handshake with whole-pipeline stall; the fixed model has no flow control.
- Sits between the window/line-buffer stage and the median/rank selection stages.

Parameters:
- DSIZE, 8, bits per lane.
- NUM, 25, total lane count, 2..64.
- GSIZE, 4, lanes per sort group, 2..16.
- BYPASS, 2, leading lanes not sorted, only delayed. Must satisfy 0 <= BYPASS < NUM.

Ports:
- clock, input, 1, sole clock; all logic is on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, in_data holds a valid vector this cycle.
- in_ready, output, 1, block accepts the vector this cycle.
- in_data, input, NUM*DSIZE, lane k occupies bits [k*DSIZE +: DSIZE].
- out_valid, output, 1, out_data holds a valid vector.
- out_ready, input, 1, downstream accepts out_data this cycle.
- out_data, output, NUM*DSIZE, same lane packing as in_data.

Behaviour:
- Reset:
  - rst is asynchronous and active-high. While asserted, every pipeline data register is 0 and every valid bit is 0.
  - Therefore out_valid=0 and out_data=0 during reset. in_ready=1 during reset, but no transfer is captured.
- Latency:
  - LAT = GSIZE register stages, counted from an accepted input to out_valid, with no stall.
  - Stage s (s=0..GSIZE-1) registers one compare-exchange layer.
  - Even s compares pairs (0,1),(2,3)…; odd s compares pairs (1,2),(3,4)… Pairs are group-local indices.
- Sort order:
  - Unsigned compare, ascending by group-local index: after LAT, the lowest lane of each group holds the minimum.
  - Equal values do not swap.
- Tail group:
  - Size T=(NUM-BYPASS) mod GSIZE. When T>=2 it is sorted by the same layers restricted to T lanes.
  - Its extra stages are pure delay, so the tail has the same LAT.
  - When T=1 the single lane is delayed only.
- Bypass lanes are delayed by LAT registers and not modified.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall. It is combinational and does not depend on in_valid.
  - Transfer in: in_valid & in_ready.
  - When stall=1, every stage register and valid bit holds its value.
  - When stall=0, every stage advances one position. The stage-0 valid bit loads in_valid & in_ready.
  - Bubbles propagate; data in invalid stages is don't-care but still shifts.
- Throughput: one vector per cycle when out_ready=1 continuously.
- Ordering: vectors leave in acceptance order; none are dropped or duplicated.
- Simultaneous events:
  - Input accept and output drain in the same cycle is legal when stall=0.
  - out_ready deasserted while out_valid=0 does not stall.
- Reset mid-operation flushes all in-flight vectors. The first vector accepted after reset release appears LAT unstalled cycles later.
- Elaboration checks: static assertion fails if GSIZE>NUM-BYPASS, GSIZE<2, or DSIZE<1.

Optional Feature:
- Macro: ORDER_SORT_DIR_EN.
- Defined:
  - Adds input port sort_desc (1 bit), sampled with each accepted vector and carried down the pipeline with it.
  - Vectors with sort_desc=1 sort descending, lowest lane = maximum.
  - Direction can change vector-to-vector without a pipeline flush.
- Undefined: port absent, ascending only; logic identical to sort_desc tied to 0.

Decomposition:
- Package order_pkg holds:
  - Function order_group_cnt(NUM,BYPASS,GSIZE), the full group count.
  - Function order_tail_size(...).
  - Constant ORDER_LAT_OF(GSIZE).
  - Lane-slice helper macros shared with the other order_* blocks.
- One sub-module, order_sort_stage:
  - One registered compare-exchange layer for a single group.
  - Parameters DSIZE, N, ODD.
  - Ports: clock, rst, enable (~stall), optional desc.
  - Generated per group and per stage; bypass delay stays inline.

Test Plan:
- Default params, in_data lanes 2..5 = {9,3,7,1}, lanes 0,1 = {0xAA,0x55}, out_ready=1 -> after 4 cycles, out lanes 2..5 = {1,3,7,9} and lanes 0,1 = {0xAA,0x55}.
- Tail group lanes 22..24 = {200,5,5} -> output {5,5,200}; equal values unchanged; same cycle as full groups.
- Streaming 10 vectors back-to-back, out_ready=1 -> 10 consecutive out_valid cycles, in order, each correctly sorted.
- out_ready=0 for 6 cycles mid-stream -> in_ready=0 while out_valid=1, outputs frozen, no vector lost; resume yields the original sequence.
- Assert rst with 3 vectors in flight -> out_valid=0 and out_data=0 immediately (asynchronous); next accepted vector appears after exactly 4 cycles.
- ORDER_SORT_DIR_EN defined, alternating sort_desc on {9,3,7,1} -> outputs alternate {1,3,7,9} / {9,7,3,1}.

Source files
------------

// File: rtl/order_pkg.sv
// order_pkg: sizing helpers, direction type and lane-slice macros shared by the order_* blocks.
`ifndef ORDER_PKG_MACROS
`define ORDER_PKG_MACROS
`define ORDER_LANE(bus, k, w) bus[(k)*(w) +: (w)]
`define ORDER_LAT_OF(gsize) (gsize)
`endif

package order_pkg;

  typedef enum logic {
    ORDER_ASC  = 1'b0,
    ORDER_DESC = 1'b1
  } order_dir_e;

  function automatic int unsigned order_group_cnt(input int unsigned num,
                                                  input int unsigned bypass,
                                                  input int unsigned gsize);
    return (num - bypass) / gsize;
  endfunction

  function automatic int unsigned order_tail_size(input int unsigned num,
                                                  input int unsigned bypass,
                                                  input int unsigned gsize);
    return (num - bypass) % gsize;
  endfunction

endpackage

// File: rtl/order_sort_stage.sv
// order_sort_stage: one registered odd-even compare-exchange layer over an N-lane group.
module order_sort_stage #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned ODD   = 0
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               enable,
  input  logic               desc,
  input  logic [N*DSIZE-1:0] d,
  output logic [N*DSIZE-1:0] q
);
  import order_pkg::*;

  order_dir_e         dir;
  logic [N*DSIZE-1:0] x;
  logic [DSIZE-1:0]   a;
  logic [DSIZE-1:0]   b;

  assign dir = desc ? ORDER_DESC : ORDER_ASC;

  // Pairs never overlap within a layer, so every exchange reads the unmodified input.
  always_comb begin
    x = d;
    a = '0;
    b = '0;
    for (int unsigned i = ODD; i + 1 < N; i += 2) begin
      a = `ORDER_LANE(d, i, DSIZE);
      b = `ORDER_LANE(d, i + 1, DSIZE);
      if ((dir == ORDER_DESC) ? (a < b) : (a > b)) begin
        `ORDER_LANE(x, i, DSIZE)     = b;
        `ORDER_LANE(x, i + 1, DSIZE) = a;
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (enable) begin
      q <= x;
    end
  end

endmodule

// File: rtl/order_group_sort.sv
// order_group_sort: per-group pipelined odd-even transposition sort with valid/ready stall.
// Optional ORDER_SORT_DIR_EN adds a per-vector sort_desc input.
module order_group_sort #(
  parameter int unsigned DSIZE  = 8,
  parameter int unsigned NUM    = 25,
  parameter int unsigned GSIZE  = 4,
  parameter int unsigned BYPASS = 2
) (
  input  logic                 clock,
  input  logic                 rst,
`ifdef ORDER_SORT_DIR_EN
  input  logic                 sort_desc,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM*DSIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM*DSIZE-1:0] out_data
);
  import order_pkg::*;

  localparam int unsigned LAT  = `ORDER_LAT_OF(GSIZE);
  localparam int unsigned NGRP = order_group_cnt(NUM, BYPASS, GSIZE);
  localparam int unsigned TAIL = order_tail_size(NUM, BYPASS, GSIZE);
  localparam int unsigned NALL = NGRP + ((TAIL > 0) ? 1 : 0);

  if (GSIZE < 2 || DSIZE < 1 || BYPASS >= NUM || GSIZE > NUM - BYPASS) begin : g_bad_params
    $error("order_group_sort: illegal parameter combination");
  end

  logic           stall;
  logic           enable;
  logic           dir_in;
  logic [LAT-1:0] vld;
  logic [LAT-2:0] dir;
  logic [LAT-1:0] dsel;

`ifdef ORDER_SORT_DIR_EN
  assign dir_in = sort_desc;
`else
  assign dir_in = 1'b0;
`endif

  assign stall     = out_valid & ~out_ready;
  assign enable    = ~stall;
  assign in_ready  = ~stall;
  assign out_valid = vld[LAT-1];
  // dsel[s] is the direction of the vector entering stage s.
  assign dsel      = {dir, dir_in};

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      vld <= '0;
      dir <= '0;
    end else if (enable) begin
      vld <= {vld[LAT-2:0], in_valid & in_ready};
      dir <= dsel[LAT-2:0];
    end
  end

  if (BYPASS > 0) begin : g_byp
    logic [BYPASS*DSIZE-1:0] byp [LAT];

    always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
        for (int unsigned s = 0; s < LAT; s++) byp[s] <= '0;
      end else if (enable) begin
        byp[0] <= in_data[BYPASS*DSIZE-1:0];
        for (int unsigned s = 1; s < LAT; s++) byp[s] <= byp[s-1];
      end
    end

    assign out_data[BYPASS*DSIZE-1:0] = byp[LAT-1];
  end

  // The tail group runs all LAT layers on T lanes; layers past T see sorted data and act as delay.
  for (genvar g = 0; g < NALL; g++) begin : grp
    localparam int unsigned GN = (g < NGRP) ? GSIZE : TAIL;
    localparam int unsigned LO = (BYPASS + g * GSIZE) * DSIZE;

    logic [GN*DSIZE-1:0] gd [LAT+1];

    assign gd[0] = in_data[LO +: GN*DSIZE];

    for (genvar s = 0; s < LAT; s++) begin : stg
      order_sort_stage #(
        .DSIZE (DSIZE),
        .N     (GN),
        .ODD   (s % 2)
      ) u_stage (
        .clock  (clock),
        .rst    (rst),
        .enable (enable),
        .desc   (dsel[s]),
        .d      (gd[s]),
        .q      (gd[s+1])
      );
    end

    assign out_data[LO +: GN*DSIZE] = gd[LAT];
  end

endmodule
